// File: rtl/puf_soc_pkg.sv
// Shared definitions for the PUF SoC top-level controller: state encodings
// and the select-width helper derived from the ring-oscillator mux length.
package puf_soc_pkg;

  localparam int unsigned MUX_LENGTH_DEF = 16;

  // Select width for a mux of the given length; a 1-entry mux still needs one bit.
  function automatic int unsigned sel_width(input int unsigned mux_length);
    return (mux_length > 1) ? $clog2(mux_length) : 1;
  endfunction

  localparam int unsigned SEL_W_DEF = sel_width(MUX_LENGTH_DEF);

  typedef enum logic [2:0] {
    FSM_RESET      = 3'd0,
    FSM_WAIT       = 3'd1,
    FSM_RECEIVE    = 3'd2,
    FSM_RO_DECODER = 3'd3,
    FSM_EXECUTE    = 3'd4,
    FSM_TRANSMIT   = 3'd5,
    FSM_DUMP       = 3'd6
  } fsm_state_e;

endpackage

// File: rtl/puf_soc_cntrlr_if.sv
// Handshake bundle between the sequencing controller and the RX datapath,
// RO muxes, execution unit and TX/dump datapath.
interface puf_soc_cntrlr_if
  import puf_soc_pkg::*;
#(
  parameter int unsigned MUX_LENGTH = MUX_LENGTH_DEF
) ();

  localparam int unsigned W = sel_width(MUX_LENGTH);

  // Datapath -> controller
  logic             i_start;
  logic             i_op_mode;
  logic             i_rx_ready;
  logic             i_rx_valid;
  logic             i_rx_done;
  logic [2*W-1:0]   i_rx_data;
  logic             i_exec_done;
  logic             i_tx_done;

  // Controller -> datapath
  logic [2:0]       o_fsm_state;
  logic             o_dcod_ready;
  logic             o_dcod_enable;
  logic             o_exec_enable;
  logic             o_tx_enable;
  logic             o_dump_enable;
  logic [W-1:0]     o_sel_mux_0;
  logic [W-1:0]     o_sel_mux_1;

  // Controller side
  modport slave (
    input  i_start, i_op_mode, i_rx_ready, i_rx_valid, i_rx_done, i_rx_data,
           i_exec_done, i_tx_done,
    output o_fsm_state, o_dcod_ready, o_dcod_enable, o_exec_enable,
           o_tx_enable, o_dump_enable, o_sel_mux_0, o_sel_mux_1
  );

  // Surrounding datapath side
  modport master (
    output i_start, i_op_mode, i_rx_ready, i_rx_valid, i_rx_done, i_rx_data,
           i_exec_done, i_tx_done,
    input  o_fsm_state, o_dcod_ready, o_dcod_enable, o_exec_enable,
           o_tx_enable, o_dump_enable, o_sel_mux_0, o_sel_mux_1
  );

endinterface

// File: rtl/puf_soc_cntrlr.sv
// Top-level sequencing FSM of the PUF SoC: waits for a start request,
// captures one challenge word as two RO mux selects, then steps through
// decode, measurement and either transmit or debug dump.
module puf_soc_cntrlr
  import puf_soc_pkg::*;
#(
  parameter int unsigned MUX_LENGTH = MUX_LENGTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  puf_soc_cntrlr_if.slave  bus
);

  localparam int unsigned W = sel_width(MUX_LENGTH);

  localparam logic [2:0] S_RESET      = FSM_RESET;
  localparam logic [2:0] S_WAIT       = FSM_WAIT;
  localparam logic [2:0] S_RECEIVE    = FSM_RECEIVE;
  localparam logic [2:0] S_RO_DECODER = FSM_RO_DECODER;
  localparam logic [2:0] S_EXECUTE    = FSM_EXECUTE;
  localparam logic [2:0] S_TRANSMIT   = FSM_TRANSMIT;
  localparam logic [2:0] S_DUMP       = FSM_DUMP;

  logic [2:0]   state_q, state_d;
  logic [W-1:0] sel0_q, sel0_d;
  logic [W-1:0] sel1_q, sel1_d;
  logic         capture;

  // The challenge word is taken on the same edge that leaves RECEIVE.
  assign capture = (state_q == S_RECEIVE) && bus.i_rx_valid && bus.i_rx_done;

  // Next-state logic; the unused encoding 7 falls back to RESET.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RESET:      state_d = S_WAIT;
      S_WAIT:       if (bus.i_start && bus.i_rx_ready) state_d = S_RECEIVE;
      S_RECEIVE:    if (capture) state_d = S_RO_DECODER;
      S_RO_DECODER: state_d = S_EXECUTE;
      S_EXECUTE: begin
        // Debug request wins over a simultaneous completion.
        if (bus.i_op_mode)        state_d = S_DUMP;
        else if (bus.i_exec_done) state_d = S_TRANSMIT;
      end
      S_TRANSMIT:   if (bus.i_tx_done) state_d = S_RESET;
      S_DUMP:       if (bus.i_tx_done) state_d = S_RESET;
      default:      state_d = S_RESET;
    endcase
  end

  // Select capture: cleared in RESET, loaded on the RECEIVE exit, held otherwise.
  always_comb begin
    sel0_d = sel0_q;
    sel1_d = sel1_q;
    if (state_q == S_RESET) begin
      sel0_d = '0;
      sel1_d = '0;
    end else if (capture) begin
      sel1_d = bus.i_rx_data[2*W-1:W];
      sel0_d = bus.i_rx_data[W-1:0];
    end
  end

  // State and select registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RESET;
      sel0_q  <= '0;
      sel1_q  <= '0;
    end else begin
      state_q <= state_d;
      sel0_q  <= sel0_d;
      sel1_q  <= sel1_d;
    end
  end

  // Moore decode: exactly one enable per active state, none in RESET/WAIT.
  always_comb begin
    bus.o_dcod_ready  = 1'b0;
    bus.o_dcod_enable = 1'b0;
    bus.o_exec_enable = 1'b0;
    bus.o_tx_enable   = 1'b0;
    bus.o_dump_enable = 1'b0;
    case (state_q)
      S_RECEIVE:    bus.o_dcod_ready  = 1'b1;
      S_RO_DECODER: bus.o_dcod_enable = 1'b1;
      S_EXECUTE:    bus.o_exec_enable = 1'b1;
      S_TRANSMIT:   bus.o_tx_enable   = 1'b1;
      S_DUMP:       bus.o_dump_enable = 1'b1;
      default:      ;
    endcase
  end

  assign bus.o_fsm_state = state_q;
  assign bus.o_sel_mux_0 = sel0_q;
  assign bus.o_sel_mux_1 = sel1_q;

endmodule

// File: tb/tb_puf_soc_cntrlr.sv
// Directed plus randomized bench for puf_soc_cntrlr with a transaction-level
// reference model of the sequencing rules.
module tb_puf_soc_cntrlr;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  puf_soc_cntrlr_if #(.MUX_LENGTH(16)) bus ();

  puf_soc_cntrlr #(.MUX_LENGTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: phase number and captured selects.
  int         m_st;
  logic [3:0] m_s0;
  logic [3:0] m_s1;

  // Expected {dcod_ready, dcod_enable, exec_enable, tx_enable, dump_enable} per phase.
  logic [4:0] en_tab [7];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    if (!rst_n) begin
      m_st = 0; m_s0 = '0; m_s1 = '0;
      return;
    end
    case (m_st)
      0: begin m_st = 1; m_s0 = '0; m_s1 = '0; end
      1: if (bus.i_start && bus.i_rx_ready) m_st = 2;
      2: if (bus.i_rx_valid && bus.i_rx_done) begin
           m_s1 = bus.i_rx_data[7:4];
           m_s0 = bus.i_rx_data[3:0];
           m_st = 3;
         end
      3: m_st = 4;
      4: if (bus.i_op_mode) m_st = 6;
         else if (bus.i_exec_done) m_st = 5;
      5, 6: if (bus.i_tx_done) m_st = 0;
      default: m_st = 0;
    endcase
  endtask

  task automatic check_all();
    logic [4:0] en;
    en = {bus.o_dcod_ready, bus.o_dcod_enable, bus.o_exec_enable, bus.o_tx_enable, bus.o_dump_enable};
    chk("state", 32'(bus.o_fsm_state), 32'(m_st));
    chk("enables", 32'(en), 32'(en_tab[m_st]));
    chk("onehot", 32'($countones(en) <= 1), 32'd1);
    chk("sel0", 32'(bus.o_sel_mux_0), 32'(m_s0));
    chk("sel1", 32'(bus.o_sel_mux_1), 32'(m_s1));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic clear_inputs();
    bus.i_start = 0; bus.i_op_mode = 0; bus.i_rx_ready = 0; bus.i_rx_valid = 0;
    bus.i_rx_done = 0; bus.i_rx_data = '0; bus.i_exec_done = 0; bus.i_tx_done = 0;
  endtask

  // Asynchronous reset pulse between edges; outputs must clear without a clock.
  task automatic async_reset(input string tag);
    #2 rst_n = 0;
    #1;
    m_st = 0; m_s0 = '0; m_s1 = '0;
    chk({tag, "_state"}, 32'(bus.o_fsm_state), 32'd0);
    chk({tag, "_en"}, 32'({bus.o_dcod_ready, bus.o_dcod_enable, bus.o_exec_enable,
                           bus.o_tx_enable, bus.o_dump_enable}), 32'd0);
    chk({tag, "_sel"}, 32'({bus.o_sel_mux_1, bus.o_sel_mux_0}), 32'd0);
    tick();
    rst_n = 1;
  endtask

  // Drive one challenge from WAIT through to EXECUTE.
  task automatic to_execute(input logic [7:0] data);
    bus.i_start = 1; bus.i_rx_ready = 1; tick();
    bus.i_start = 0; bus.i_rx_ready = 0;
    bus.i_rx_valid = 1; bus.i_rx_done = 1; bus.i_rx_data = data; tick();
    bus.i_rx_valid = 0; bus.i_rx_done = 0; tick();
  endtask

  initial begin
    checks = 0; failures = 0;
    en_tab = '{5'b00000, 5'b00000, 5'b10000, 5'b01000, 5'b00100, 5'b00010, 5'b00001};
    m_st = 0; m_s0 = '0; m_s1 = '0;
    clear_inputs();
    rst_n = 0;

    // Reset held for five cycles
    repeat (5) tick();
    chk("reset_state", 32'(bus.o_fsm_state), 32'd0);
    rst_n = 1;
    tick();
    chk("wait_after_reset", 32'(bus.o_fsm_state), 32'd1);

    // Start without receiver ready stalls in WAIT
    bus.i_start = 1; tick(); tick();
    chk("stall_wait", 32'(bus.o_fsm_state), 32'd1);

    // Normal flow with 0xA5
    bus.i_rx_ready = 1; tick();
    chk("recv_ready", 32'(bus.o_dcod_ready), 32'd1);
    bus.i_start = 0; bus.i_rx_ready = 0;
    bus.i_rx_valid = 1; bus.i_rx_data = 8'hA5; bus.i_exec_done = 1; tick(); tick();
    chk("stall_recv", 32'(bus.o_fsm_state), 32'd2);
    chk("stall_sel", 32'({bus.o_sel_mux_1, bus.o_sel_mux_0}), 32'h00);
    bus.i_exec_done = 0; bus.i_rx_done = 1; tick();
    chk("cap_sel1", 32'(bus.o_sel_mux_1), 32'hA);
    chk("cap_sel0", 32'(bus.o_sel_mux_0), 32'h5);
    chk("dcod_en", 32'(bus.o_dcod_enable), 32'd1);
    bus.i_rx_valid = 0; bus.i_rx_done = 0; bus.i_rx_data = 8'hFF; bus.i_tx_done = 1; tick(); tick();
    chk("exec_hold", 32'(bus.o_exec_enable), 32'd1);
    bus.i_tx_done = 0; bus.i_exec_done = 1; tick();
    chk("tx_en", 32'(bus.o_tx_enable), 32'd1);
    bus.i_exec_done = 0; tick();
    chk("tx_hold_sel", 32'({bus.o_sel_mux_1, bus.o_sel_mux_0}), 32'hA5);
    bus.i_tx_done = 1; tick();
    chk("tx_to_reset", 32'(bus.o_fsm_state), 32'd0);
    bus.i_tx_done = 0; tick();

    // Debug flow with a one-cycle op_mode pulse
    to_execute(8'h5A);
    bus.i_op_mode = 1; tick();
    bus.i_op_mode = 0;
    chk("dump_en", 32'(bus.o_dump_enable), 32'd1);
    tick();
    bus.i_tx_done = 1; tick();
    chk("dump_to_reset", 32'(bus.o_fsm_state), 32'd0);
    bus.i_tx_done = 0; tick();

    // op_mode has priority over exec_done
    to_execute(8'h96);
    bus.i_op_mode = 1; bus.i_exec_done = 1; tick();
    chk("prio_dump", 32'(bus.o_fsm_state), 32'd6);
    bus.i_op_mode = 0; bus.i_exec_done = 0; bus.i_tx_done = 1; tick();
    bus.i_tx_done = 0; tick();

    // Reset in the middle of EXECUTE
    to_execute(8'hF0);
    async_reset("midop");
    tick();
    chk("midop_wait", 32'(bus.o_fsm_state), 32'd1);

    // Back-to-back transactions with start and ready held high
    bus.i_start = 1; bus.i_rx_ready = 1; tick();
    bus.i_rx_valid = 1; bus.i_rx_done = 1; bus.i_rx_data = 8'hA5; tick();
    bus.i_rx_valid = 0; bus.i_rx_done = 0; tick();
    bus.i_exec_done = 1; tick();
    bus.i_exec_done = 0; bus.i_tx_done = 1; tick();
    bus.i_tx_done = 0;
    chk("b2b_reset", 32'(bus.o_fsm_state), 32'd0);
    tick();
    chk("b2b_wait", 32'(bus.o_fsm_state), 32'd1);
    tick();
    chk("b2b_recv", 32'(bus.o_fsm_state), 32'd2);
    bus.i_rx_valid = 1; bus.i_rx_done = 1; bus.i_rx_data = 8'h3C; tick();
    chk("b2b_sel1", 32'(bus.o_sel_mux_1), 32'h3);
    chk("b2b_sel0", 32'(bus.o_sel_mux_0), 32'hC);
    clear_inputs();
    tick();

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      bus.i_start     = ($urandom_range(0, 3) != 0);
      bus.i_rx_ready  = ($urandom_range(0, 3) != 0);
      bus.i_rx_valid  = ($urandom_range(0, 1) != 0);
      bus.i_rx_done   = ($urandom_range(0, 1) != 0);
      bus.i_rx_data   = 8'($urandom);
      bus.i_op_mode   = ($urandom_range(0, 7) == 0);
      bus.i_exec_done = ($urandom_range(0, 3) == 0);
      bus.i_tx_done   = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 199) == 0) async_reset("rand_rst");
      else tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
